// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier datapath: default widths and the
// accumulator state encoding used by mult_accumulator.
package multiplier_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    // EMPTY: no beat of the current vector accepted yet (sum/count are zero).
    // ACTIVE: at least one beat accepted, last not yet seen.
    typedef enum logic {
        ACC_EMPTY  = 1'b0,
        ACC_ACTIVE = 1'b1
    } acc_state_e;

endpackage

// File: rtl/mult_accumulator_if.sv
// Product-in / result-out handshake bundle for mult_accumulator.
// slave: the accumulator itself; master: the environment around it.
interface mult_accumulator_if
    import multiplier_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              prod_valid_i;
    logic              prod_ready_o;
    logic [PROD_W-1:0] product_i;
    logic              prod_last_i;
    logic              acc_valid_o;
    logic              acc_ready_i;
    logic [ACC_W-1:0]  acc_data_o;
    logic [CNT_W-1:0]  acc_count_o;
    logic              acc_overflow_o;

    modport slave (
        input  prod_valid_i, product_i, prod_last_i, acc_ready_i,
        output prod_ready_o, acc_valid_o, acc_data_o, acc_count_o, acc_overflow_o
    );

    modport master (
        output prod_valid_i, product_i, prod_last_i, acc_ready_i,
        input  prod_ready_o, acc_valid_o, acc_data_o, acc_count_o, acc_overflow_o
    );

endinterface

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums the product stream one vector (delimited by last)
// at a time and hands each vector's sum, beat count and overflow flag to a
// single-entry result slot, so the next vector can accumulate while the
// previous result waits for the consumer.
// Optional feature macro MULT_ACC_SAT_EN: when defined, the running sum
// saturates at all-ones on carry instead of wrapping. Overflow is reported
// either way.
module mult_accumulator
    import multiplier_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mult_accumulator_if.slave  bus
);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             slot_valid_q, slot_valid_d;
    logic [ACC_W-1:0] slot_data_q, slot_data_d;
    logic [CNT_W-1:0] slot_count_q, slot_count_d;
    logic             slot_ovf_q, slot_ovf_d;

    logic             prod_ready;
    logic             accept;
    logic [ACC_W-1:0] base_sum;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] sum_beat;
    logic [CNT_W-1:0] cnt_beat;
    logic             ovf_beat;

    // Handshake and per-beat arithmetic: what the vector totals become if this beat is taken.
    always_comb begin
        // Only a last beat can be stalled, and only when the slot is full and not draining.
        prod_ready = !(bus.prod_last_i && slot_valid_q && !bus.acc_ready_i);
        accept     = bus.prod_valid_i && prod_ready;

        if (state_q == ACC_EMPTY) begin
            base_sum = {ACC_W{1'b0}};
            base_cnt = {CNT_W{1'b0}};
            base_ovf = 1'b0;
        end else begin
            base_sum = sum_q;
            base_cnt = cnt_q;
            base_ovf = ovf_q;
        end

        sum_ext = {1'b0, base_sum} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product_i};
        carry   = sum_ext[ACC_W];
`ifdef MULT_ACC_SAT_EN
        // Once saturated, any further nonzero product carries again, so the sum stays pinned.
        if (carry) begin
            sum_beat = {ACC_W{1'b1}};
        end else begin
            sum_beat = sum_ext[ACC_W-1:0];
        end
`else
        sum_beat = sum_ext[ACC_W-1:0];
`endif
        if (&base_cnt) begin
            cnt_beat = base_cnt;
        end else begin
            cnt_beat = base_cnt + CNT_W'(1);
        end
        ovf_beat = base_ovf | carry;
    end

    // Accumulator FSM next-state and running totals.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC_EMPTY, ACC_ACTIVE: begin
                if (accept && bus.prod_last_i) begin
                    state_d = ACC_EMPTY;
                end else if (accept) begin
                    state_d = ACC_ACTIVE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ACC_EMPTY;
        endcase

        if (accept && bus.prod_last_i) begin
            // Totals move to the slot; the next vector starts from zero.
            sum_d = {ACC_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
        end else if (accept) begin
            sum_d = sum_beat;
            cnt_d = cnt_beat;
            ovf_d = ovf_beat;
        end else begin
            sum_d = sum_q;
            cnt_d = cnt_q;
            ovf_d = ovf_q;
        end
    end

    // Result slot: load on last beat (wins over a same-edge drain), clear on handshake, else hold.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        slot_count_d = slot_count_q;
        slot_ovf_d   = slot_ovf_q;
        if (accept && bus.prod_last_i) begin
            slot_valid_d = 1'b1;
            slot_data_d  = sum_beat;
            slot_count_d = cnt_beat;
            slot_ovf_d   = ovf_beat;
        end else if (slot_valid_q && bus.acc_ready_i) begin
            slot_valid_d = 1'b0;
        end else begin
            slot_valid_d = slot_valid_q;
        end
    end

    // State, accumulator and slot registers; reset drops any partial vector and held result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ACC_EMPTY;
            sum_q        <= {ACC_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            ovf_q        <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_data_q  <= {ACC_W{1'b0}};
            slot_count_q <= {CNT_W{1'b0}};
            slot_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            slot_count_q <= slot_count_d;
            slot_ovf_q   <= slot_ovf_d;
        end
    end

    assign bus.prod_ready_o   = prod_ready;
    assign bus.acc_valid_o    = slot_valid_q;
    assign bus.acc_data_o     = slot_data_q;
    assign bus.acc_count_o    = slot_count_q;
    assign bus.acc_overflow_o = slot_ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench for mult_accumulator: directed scenarios plus a
// randomized stream scored against a vector-level reference model
// (sum of products, saturated or wrapped, count clipped at all-ones).
module tb_mult_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic [CNT_W-1:0] c;
        logic             o;
    } res_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mult_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mult_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result of a whole vector from its arithmetic total and beat count.
    function automatic res_t exp_of(longint total, int n);
        res_t   r;
        longint maxv;
        longint maxc;
        maxv = (64'sd1 <<< ACC_W) - 64'sd1;
        maxc = (64'sd1 <<< CNT_W) - 64'sd1;
`ifdef MULT_ACC_SAT_EN
        if (total > maxv) r.d = maxv[ACC_W-1:0];
        else              r.d = total[ACC_W-1:0];
`else
        r.d = total[ACC_W-1:0];
`endif
        if (longint'(n) > maxc) r.c = maxc[CNT_W-1:0];
        else                    r.c = CNT_W'(n);
        r.o = (total > maxv);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PROD_W-1:0] p, input logic l);
        bus.prod_valid_i = v;
        bus.product_i    = p;
        bus.prod_last_i  = l;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.prod_valid_i = 1'($urandom);
            bus.product_i    = PROD_W'($urandom);
            bus.prod_last_i  = 1'($urandom);
            bus.acc_ready_i  = 1'($urandom);
            @(negedge clk);
            checks += 4;
            if (bus.acc_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.acc_valid_o); end
            if (bus.prod_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", bus.prod_ready_o); end
            if (bus.acc_data_o !== 24'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.acc_data_o); end
            if (bus.acc_count_o !== 8'h0 || bus.acc_overflow_o !== 1'b0) begin
                errors++; $display("FAIL reset_count_ovf: got %0h/%0b expected 0/0", bus.acc_count_o, bus.acc_overflow_o);
            end
            cyc();
        end
        drive(1'b0, 16'h0, 1'b0);
        bus.acc_ready_i = 1'b1;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        bus.acc_ready_i = 1'b1;
        drive(1'b1, 16'd3, 1'b0); cyc();
        drive(1'b1, 16'd5, 1'b0); cyc();
        drive(1'b1, 16'd7, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.acc_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early: got %0b expected 0", bus.acc_valid_o); end
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        @(negedge clk);
        checks += 3;
        if (bus.acc_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", bus.acc_valid_o); end
        if (bus.acc_data_o !== 24'd15) begin errors++; $display("FAIL basic_data: got %0d expected 15", bus.acc_data_o); end
        if (bus.acc_count_o !== 8'd3 || bus.acc_overflow_o !== 1'b0) begin
            errors++; $display("FAIL basic_count_ovf: got %0d/%0b expected 3/0", bus.acc_count_o, bus.acc_overflow_o);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (bus.acc_valid_o !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %0b expected 0", bus.acc_valid_o); end
        cyc();
    endtask

    task automatic test_single_beat();
        bus.acc_ready_i = 1'b1;
        drive(1'b1, 16'hFFFF, 1'b1); cyc();
        drive(1'b0, 16'h0, 1'b0);
        @(negedge clk);
        checks += 2;
        if (bus.acc_valid_o !== 1'b1 || bus.acc_data_o !== 24'h00FFFF) begin
            errors++; $display("FAIL single_data: got %0b/%0h expected 1/00ffff", bus.acc_valid_o, bus.acc_data_o);
        end
        if (bus.acc_count_o !== 8'd1 || bus.acc_overflow_o !== 1'b0) begin
            errors++; $display("FAIL single_count_ovf: got %0d/%0b expected 1/0", bus.acc_count_o, bus.acc_overflow_o);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        bus.acc_ready_i = 1'b0;
        drive(1'b1, 16'd1, 1'b0); cyc();
        drive(1'b1, 16'd2, 1'b1); cyc();
        drive(1'b1, 16'd10, 1'b0);
        @(negedge clk);
        checks += 2;
        if (bus.acc_valid_o !== 1'b1 || bus.acc_data_o !== 24'd3) begin
            errors++; $display("FAIL bp_hold_a: got %0b/%0d expected 1/3", bus.acc_valid_o, bus.acc_data_o);
        end
        if (bus.prod_ready_o !== 1'b1) begin errors++; $display("FAIL bp_nonlast_ready: got %0b expected 1", bus.prod_ready_o); end
        cyc();
        drive(1'b1, 16'd20, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.prod_ready_o !== 1'b0) begin errors++; $display("FAIL bp_last_stall: got %0b expected 0", bus.prod_ready_o); end
        cyc();
        @(negedge clk);
        checks += 2;
        if (bus.acc_data_o !== 24'd3 || bus.acc_count_o !== 8'd2) begin
            errors++; $display("FAIL bp_stable: got %0d/%0d expected 3/2", bus.acc_data_o, bus.acc_count_o);
        end
        if (bus.prod_ready_o !== 1'b0) begin errors++; $display("FAIL bp_still_stall: got %0b expected 0", bus.prod_ready_o); end
        bus.acc_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.prod_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b expected 1", bus.prod_ready_o); end
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        bus.acc_ready_i = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.acc_valid_o !== 1'b1 || bus.acc_data_o !== 24'd30) begin
            errors++; $display("FAIL bp_b_data: got %0b/%0d expected 1/30", bus.acc_valid_o, bus.acc_data_o);
        end
        if (bus.acc_count_o !== 8'd2) begin errors++; $display("FAIL bp_b_count: got %0d expected 2", bus.acc_count_o); end
        bus.acc_ready_i = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (bus.acc_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b expected 0", bus.acc_valid_o); end
        cyc();
    endtask

    task automatic test_overflow();
        res_t e;
        e = exp_of(longint'(257) * longint'(16'hFFFF), 257);
        bus.acc_ready_i = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 16'hFFFF, (i == 256));
            cyc();
        end
        drive(1'b0, 16'h0, 1'b0);
        @(negedge clk);
        checks += 3;
        if (bus.acc_valid_o !== 1'b1 || bus.acc_data_o !== e.d) begin
            errors++; $display("FAIL ovf_data: got %0b/%0h expected 1/%0h", bus.acc_valid_o, bus.acc_data_o, e.d);
        end
        if (bus.acc_count_o !== e.c) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", bus.acc_count_o, e.c); end
        if (bus.acc_overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", bus.acc_overflow_o); end
        cyc();
    endtask

    task automatic test_reset_mid_vector();
        int seen;
        bus.acc_ready_i = 1'b0;
        drive(1'b1, 16'd7, 1'b1); cyc();
        drive(1'b1, 16'd4, 1'b0); cyc();
        drive(1'b1, 16'd4, 1'b0); cyc();
        drive(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.acc_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %0b expected 0", bus.acc_valid_o); end
        cyc();
        rst = 1'b1;
        bus.acc_ready_i = 1'b1;
        drive(1'b1, 16'd9, 1'b1); cyc();
        drive(1'b0, 16'h0, 1'b0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.acc_valid_o === 1'b1) begin
                seen++;
                checks++;
                if (bus.acc_data_o !== 24'd9 || bus.acc_count_o !== 8'd1) begin
                    errors++; $display("FAIL midrst_result: got %0d/%0d expected 9/1", bus.acc_data_o, bus.acc_count_o);
                end
            end
            cyc();
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL midrst_count: got %0d results expected 1", seen); end
    endtask

    task automatic test_back_to_back();
        logic [PROD_W-1:0] vals[6];
        bus.acc_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vals[i] = PROD_W'($urandom);
            drive(1'b1, vals[i], 1'b1);
            @(negedge clk);
            checks++;
            if (bus.prod_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b expected 1", bus.prod_ready_o); end
            if (i > 0) begin
                checks++;
                if (bus.acc_valid_o !== 1'b1 || bus.acc_data_o !== {8'h0, vals[i-1]} || bus.acc_count_o !== 8'd1) begin
                    errors++;
                    $display("FAIL b2b_result: got %0b/%0h/%0d expected 1/%0h/1", bus.acc_valid_o, bus.acc_data_o, bus.acc_count_o, vals[i-1]);
                end
            end
            cyc();
        end
        drive(1'b0, 16'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.acc_valid_o !== 1'b1 || bus.acc_data_o !== {8'h0, vals[5]}) begin
            errors++; $display("FAIL b2b_tail: got %0b/%0h expected 1/%0h", bus.acc_valid_o, bus.acc_data_o, vals[5]);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [PROD_W:0] beats[$];
        res_t            exp_q[$];
        res_t            e;
        longint          tot;
        int              n;
        int              budget;
        logic [PROD_W:0] b;
        tot = 0;
        n   = 0;
        for (int v = 0; v < 40; v++) begin
            int len;
            len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                b = {(k == len - 1) ? 1'b1 : 1'b0, PROD_W'($urandom)};
                beats.push_back(b);
            end
        end
        budget = 2000;
        while ((beats.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            budget--;
            if (beats.size() > 0 && $urandom_range(0, 3) != 0) begin
                drive(1'b1, beats[0][PROD_W-1:0], beats[0][PROD_W]);
            end else begin
                drive(1'b0, PROD_W'($urandom), 1'($urandom));
            end
            if (beats.size() > 0) bus.acc_ready_i = 1'($urandom);
            else                  bus.acc_ready_i = 1'b1;
            @(negedge clk);
            if (bus.prod_valid_i && !bus.prod_last_i) begin
                checks++;
                if (bus.prod_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_nonlast_stall: got %0b expected 1", bus.prod_ready_o); end
            end
            if (bus.acc_valid_o === 1'b1 && bus.acc_ready_i === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra: got %0h expected none", bus.acc_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.acc_data_o !== e.d || bus.acc_count_o !== e.c || bus.acc_overflow_o !== e.o) begin
                        errors++;
                        $display("FAIL rnd_result: got %0h/%0d/%0b expected %0h/%0d/%0b",
                                 bus.acc_data_o, bus.acc_count_o, bus.acc_overflow_o, e.d, e.c, e.o);
                    end
                end
            end
            if (bus.prod_valid_i && bus.prod_ready_o === 1'b1) begin
                void'(beats.pop_front());
                tot += longint'(bus.product_i);
                n++;
                if (bus.prod_last_i) begin
                    exp_q.push_back(exp_of(tot, n));
                    tot = 0;
                    n   = 0;
                end
            end
            cyc();
        end
        drive(1'b0, 16'h0, 1'b0);
        checks++;
        if (budget == 0) begin
            errors++; $display("FAIL rnd_timeout: got %0d pending expected 0", beats.size() + exp_q.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        bus.acc_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_single_beat();
        test_backpressure();
        test_overflow();
        test_reset_mid_vector();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

- Downstream stage of the pipelined multiplier.
- Consumes the product stream and accumulates products into a running sum, one vector at a time. A vector is delimited by a last flag.
- Emits one result per vector, carrying the sum, beat count and overflow flag, over a valid/ready handshake.
- A single-entry result slot lets the next vector accumulate while the previous result waits for the consumer.

## Interface
Parameters:
- PROD_W, 16, width of incoming product (multiplier DOUT_W)
- ACC_W, 24, accumulator/result width, must be ≥ PROD_W
- CNT_W, 8, beat-count width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- prod_valid_i  in  1  product beat valid
- prod_ready_o  out  1  stage can accept beat
- product_i  in  PROD_W  unsigned product
- prod_last_i  in  1  beat is last of vector
- acc_valid_o  out  1  result slot holds a result
- acc_ready_i  in  1  consumer accepts result
- acc_data_o  out  ACC_W  vector sum
- acc_count_o  out  CNT_W  beats in vector, saturating at 2^CNT_W-1
- acc_overflow_o  out  1  sum exceeded ACC_W during vector

## Operation
- A beat is accepted when prod_valid_i && prod_ready_o.
- Accumulator FSM (package enum):
  - EMPTY: sum=0, count=0.
  - ACTIVE: ≥1 beat accepted, no last yet.
- Transitions:
  - EMPTY → ACTIVE on an accepted non-last beat.
  - Any state → EMPTY on an accepted last beat. The sum is cleared, so the next beat starts from zero.
- Arithmetic:
  - product_i is zero-extended to ACC_W+1 and added to the sum. Bit ACC_W is the carry.
  - Any carry sets a per-vector sticky overflow bit.
  - Count increments per accepted beat and saturates at all-ones.
- On an accepted last beat, the final sum (including that beat), count and overflow load into the result slot. acc_valid_o is set.
- Result slot:
  - Holds stable while acc_valid_o && !acc_ready_i.
  - Clears on handshake unless reloaded on the same edge.
- prod_ready_o = !(prod_last_i && acc_valid_o && !acc_ready_i).
  - Non-last beats are never stalled.
  - A last beat stalls only while the slot is occupied and not draining.
  - This is a combinational path from acc_ready_i and prod_last_i.
- Simultaneous slot drain and last-beat accept: the slot is reloaded with the new result and acc_valid_o stays 1.
- A single-beat vector (last on the first beat) yields sum=product and count=1.

## Timing
- All outputs reset to 0 while rst=0, except prod_ready_o, which is 1. FSM is EMPTY.
- Reset mid-vector discards the partial sum and any held result. No result is emitted for that vector.
- Latency: acc_valid_o rises on the edge after the last beat is accepted, i.e. 1 cycle.
- Throughput: one beat per cycle. Back-to-back single-beat vectors sustain one result per cycle when acc_ready_i=1.
- acc_data_o, acc_count_o and acc_overflow_o are registered and change only when the slot loads.

## Configuration
- MULT_ACC_SAT_EN defined:
  - The sum saturates at 2^ACC_W-1 on carry and stays saturated until the vector ends.
  - acc_overflow_o is set.
- Undefined:
  - The sum wraps modulo 2^ACC_W.
  - acc_overflow_o is still reported.

## Structure
- multiplier_pkg holds the FSM state enum (ACC_EMPTY, ACC_ACTIVE) and default ACC_W/CNT_W constants.
- No sub-module. data_pipeline is unsuitable here because this stage must hold under backpressure.

## Test plan
- Reset: hold rst=0 with random inputs. Expect acc_valid_o=0, prod_ready_o=1, acc_data_o=0, acc_count_o=0. After release, the first vector behaves normally.
- Basic vector: 3, 5, 7(last), acc_ready_i=1. Expect acc_valid_o one cycle after the 7 is accepted, data=15, count=3, overflow=0, and a one-cycle pulse.
- Single beat: 0xFFFF(last). Expect data=0x00FFFF, count=1.
- Backpressure:
  - With acc_ready_i=0, send A = {1, 2(last)}. Result 3 is held.
  - Send B = {10, 20(last)}. Beat 10 is accepted; beat 20 sees prod_ready_o=0.
  - Pulse acc_ready_i. A (3) drains, 20 is accepted on the same edge, and B's result is 30 with count=2.
- Overflow: 257 beats of 0xFFFF, last on the final beat.
  - With MULT_ACC_SAT_EN: data=0xFFFFFF, count=255, overflow=1.
  - Without it: data=0x00FEFF, count=255, overflow=1.
- Reset mid-vector: accept 4, 4; pulse rst=0 for one cycle; then send 9(last). Expect exactly one result: data=9, count=1.
